// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-bank peripheral: FSM state
// encoding and frame-geometry helpers derived from the address/data widths.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } spi_state_e;

    // Default geometry: 1 R/W bit + 7 address bits + 8 data bits.
    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_FRAME_LEN = 1 + DEF_ADDR_W + DEF_DATA_W;

    // Total bits in one frame.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Bit counter width, wide enough to hold FRAME_LEN itself.
    function automatic int cnt_width(input int addr_w, input int data_w);
        return $clog2(frame_len(addr_w, data_w) + 1);
    endfunction

    // Address of the optional status register: the top of the address space.
    function automatic int status_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/spi_regbank_peripheral_if.sv
// SPI pin bundle. The controller (master) drives nCS/SCLK/COPI; the
// peripheral (slave) drives CIPO and its pad output enable.
interface spi_regbank_peripheral_if;
    logic nCS;
    logic SCLK;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (output nCS, output SCLK, output COPI, input CIPO, input cipo_oe);
    modport slave  (input nCS, input SCLK, input COPI, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// SYNC-deep synchroniser for one asynchronous input, with single-clk
// rise/fall pulses derived from the synchronised level. RST_VAL sets the
// level the chain assumes during reset (1 for an idle-high chip select).
module spi_sync_edge #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC-1:0] sync_q;
    logic            prev_q;

    // Shift the raw input through the chain and remember the previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], d_i};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign level_o = sync_q[SYNC-1];
    assign rise_o  = ~prev_q &  level_o;
    assign fall_o  =  prev_q & ~level_o;
endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 peripheral with a read/write register bank.
// Frame: R/W bit (1 = write), address MSB-first, data MSB-first.
// All SPI pins are oversampled in the clk domain.
// Optional build macro: SPI_STATUS_REG_EN adds a read-only status register
// at the top address holding {abort count, last write hit}.
module spi_regbank_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC     = 2,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_regbank_peripheral_if.slave      spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);
    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = cnt_width(ADDR_W, DATA_W);
    // Counter value seen on the rise that carries the last address bit.
    localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(ADDR_W);
    // Falls after this many rises move the read shifter on.
    localparam logic [CNT_W-1:0] CNT_SHIFT_MIN = CNT_W'(ADDR_W + 1);
    // Counter value seen on the final data rise.
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(FRAME_LEN - 1);

    logic cs_level_unused, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic copi_s, copi_rise_unused, copi_fall_unused;

    spi_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W:0]   cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              cipo_oe_q;
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [ADDR_W:0]   cmd_d;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] rd_val;
    logic              addr_hit;
    logic              wr_commit;

`ifdef SPI_STATUS_REG_EN
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(status_addr(ADDR_W));
    logic [DATA_W-2:0] abort_cnt_q;
    logic              last_wr_ok_q;
    logic              frame_abort;
`endif

    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(spi.nCS),
        .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(spi.SCLK),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(spi.COPI),
        .level_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
    );

    assign cmd_d    = {cmd_q[ADDR_W-1:0], copi_s};
    assign data_d   = {data_q[DATA_W-2:0], copi_s};
    assign addr_hit = (addr_q < ADDR_W'(NUM_REGS));
    // The last data bit of a write arrived and no nCS edge overrides it.
    assign wr_commit = (state_q == WDATA) && sclk_rise && (cnt_q == CNT_LAST)
                       && !cs_rise && !cs_fall;

    // Readback mux, addressed by the just-completed command word.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_d[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
        end
`ifdef SPI_STATUS_REG_EN
        if (cmd_d[ADDR_W-1:0] == STATUS_A) rd_val = {abort_cnt_q, last_wr_ok_q};
`endif
    end

    // Frame FSM: nCS edges take priority, then per-state SCLK handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cipo_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (cs_fall) begin
                // Also restarts a frame if a rise/fall pair slipped past.
                state_q   <= CMD;
                cnt_q     <= '0;
                cmd_q     <= '0;
                data_q    <= '0;
                cipo_oe_q <= 1'b0;
            end else if (cs_rise) begin
                state_q   <= IDLE;
                cipo_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_q <= cmd_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_CMD_LAST) begin
                                addr_q <= cmd_d[ADDR_W-1:0];
                                if (cmd_d[ADDR_W]) begin
                                    state_q <= WDATA;
                                end else begin
                                    // MSB goes out at once so it is valid on the next rise.
                                    state_q   <= RDATA;
                                    data_q    <= rd_val;
                                    cipo_oe_q <= 1'b1;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            data_q <= data_d;
                            cnt_q  <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_LAST) begin
                                state_q <= DONE;
                                if (addr_hit) begin
                                    wr_strobe_q <= 1'b1;
                                    wr_addr_q   <= addr_q;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (sclk_rise) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_LAST) state_q <= DONE;
                        end else if (sclk_fall && (cnt_q > CNT_SHIFT_MIN)) begin
                            // The fall before the first data rise keeps the MSB.
                            data_q <= {data_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register bank: committed write lands on the addressed entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == ADDR_W'(i)) regs_q[i] <= data_d;
            end
        end
    end

`ifdef SPI_STATUS_REG_EN
    assign frame_abort = cs_rise && ((state_q == CMD) || (state_q == WDATA) || (state_q == RDATA));

    // Status: saturating abort count and hit flag of the last write frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_cnt_q  <= '0;
            last_wr_ok_q <= 1'b0;
        end else if (wr_commit) begin
            if (addr_q == STATUS_A) begin
                abort_cnt_q  <= '0;
                last_wr_ok_q <= 1'b0;
            end else begin
                last_wr_ok_q <= addr_hit;
            end
        end else if (frame_abort && !(&abort_cnt_q)) begin
            abort_cnt_q <= abort_cnt_q + (DATA_W-1)'(1);
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_out[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    assign spi.CIPO    = cipo_oe_q & data_q[DATA_W-1];
    assign spi.cipo_oe = cipo_oe_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Testbench for spi_regbank_peripheral: directed table of frames, a
// status-register sequence (SPI_STATUS_REG_EN builds), randomized frames
// against a frame-level model, and an asynchronous reset mid-frame.
module tb_spi_regbank_peripheral;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 5;
    localparam int HALF     = 8;   // clk cycles per SCLK half period

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_REGS*DATA_W-1:0]  regs_out;
    logic                        wr_strobe;
    logic [ADDR_W-1:0]           wr_addr;

    spi_regbank_peripheral_if spi ();

    spi_regbank_peripheral #(
        .SYNC(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi.slave),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    // Frame-level model state.
    logic [7:0] m_regs [NUM_REGS];
    logic [6:0] m_wr_addr;
    logic [6:0] m_abort;
    logic       m_ok;

    typedef struct {
        logic [15:0] tx;
        int          n;
        logic [7:0]  rx;
        int          stb;
        logic [6:0]  waddr;
        logic [39:0] regs;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (wr_strobe === 1'b1) strobes++;
        end
    endtask

    function automatic logic [39:0] m_flat();
        logic [39:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_wr_addr = 7'h00;
        m_abort   = 7'h00;
        m_ok      = 1'b0;
    endtask

    // Apply one frame's effect; return expected read byte and strobe count.
    task automatic model_apply(input logic [15:0] tx, input int n,
                               output logic [7:0] erx, output int estb);
        int ai;
        ai   = int'(tx[14:8]);
        erx  = 8'h00;
        estb = 0;
        if (n < 16) begin
            if (m_abort != 7'h7F) m_abort = m_abort + 7'd1;
        end else if (tx[15]) begin
            if (ai < NUM_REGS) begin
                m_regs[ai] = tx[7:0];
                m_wr_addr  = tx[14:8];
                estb       = 1;
            end
            m_ok = (ai < NUM_REGS);
`ifdef SPI_STATUS_REG_EN
            if (ai == 127) begin
                m_ok    = 1'b0;
                m_abort = 7'h00;
            end
`endif
        end else begin
            if (ai < NUM_REGS) erx = m_regs[ai];
`ifdef SPI_STATUS_REG_EN
            if (ai == 127) erx = {m_abort, m_ok};
`endif
        end
    endtask

    // Drive one frame of n SCLK rises; capture CIPO at data rises 9..16.
    task automatic do_frame(input logic [15:0] tx, input int n,
                            output logic [7:0] rx, output int nstb);
        logic rd;
        rd      = ~tx[15];
        rx      = 8'h00;
        strobes = 0;
        spi.nCS = 1'b0;
        tick(HALF);
        for (int i = 1; i <= n; i++) begin
            spi.COPI = (i <= 16) ? tx[16-i] : 1'($urandom_range(0, 1));
            tick(HALF);
            if (i >= 9 && i <= 16) rx = {rx[6:0], spi.CIPO};
            chk($sformatf("cipo_oe@rise%0d", i), spi.cipo_oe, (rd && i >= 9) ? 1 : 0);
            spi.SCLK = 1'b1;
            tick(HALF);
            spi.SCLK = 1'b0;
        end
        tick(HALF);
        spi.nCS = 1'b1;
        tick(HALF);
        nstb = strobes;
        chk("oe_idle", spi.cipo_oe, 0);
        chk("cipo_idle", spi.CIPO, 0);
        $display("frame tx=%04h rises=%0d rx=%02h strobes=%0d wr_addr=%02h regs=%010h",
                 tx, n, rx, nstb, wr_addr, regs_out);
    endtask

    initial begin
        logic [7:0] rx, erx;
        int nstb, estb;

        vecs[0]  = '{16'h82A5, 16, 8'h00, 1, 7'h02, 40'h00_00_A5_00_00};
        vecs[1]  = '{16'h843C, 16, 8'h00, 1, 7'h04, 40'h3C_00_A5_00_00};
        vecs[2]  = '{16'h0400, 16, 8'h3C, 0, 7'h04, 40'h3C_00_A5_00_00};
        vecs[3]  = '{16'h9077, 16, 8'h00, 0, 7'h04, 40'h3C_00_A5_00_00};
        vecs[4]  = '{16'h1000, 16, 8'h00, 0, 7'h04, 40'h3C_00_A5_00_00};
        vecs[5]  = '{16'h81EE, 12, 8'h00, 0, 7'h04, 40'h3C_00_A5_00_00};
        vecs[6]  = '{16'h8111, 16, 8'h00, 1, 7'h01, 40'h3C_00_A5_11_00};
        vecs[7]  = '{16'h8155, 20, 8'h00, 1, 7'h01, 40'h3C_00_A5_55_00};
        vecs[8]  = '{16'h0100, 16, 8'h55, 0, 7'h01, 40'h3C_00_A5_55_00};
        vecs[9]  = '{16'h0200, 16, 8'hA5, 0, 7'h01, 40'h3C_00_A5_55_00};
`ifdef SPI_STATUS_REG_EN
        vecs[10] = '{16'h7F00, 16, 8'h03, 0, 7'h01, 40'h3C_00_A5_55_00};
`else
        vecs[10] = '{16'h7F00, 16, 8'h00, 0, 7'h01, 40'h3C_00_A5_55_00};
`endif
        vecs[11] = '{16'h0300, 16, 8'h00, 0, 7'h01, 40'h3C_00_A5_55_00};

        model_reset();
        spi.nCS  = 1'b1;
        spi.SCLK = 1'b0;
        spi.COPI = 1'b0;

        // Reset state.
        tick(3);
        chk("rst_regs", regs_out, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_oe", spi.cipo_oe, 0);
        chk("rst_cipo", spi.CIPO, 0);
        rst_n = 1'b1;
        tick(4);

        // Directed table.
        for (int v = 0; v < 12; v++) begin
            do_frame(vecs[v].tx, vecs[v].n, rx, nstb);
            model_apply(vecs[v].tx, vecs[v].n, erx, estb);
            chk($sformatf("tbl%0d_strobes", v), nstb, vecs[v].stb);
            chk($sformatf("tbl%0d_wr_addr", v), wr_addr, vecs[v].waddr);
            chk($sformatf("tbl%0d_regs", v), regs_out, vecs[v].regs);
            if (!vecs[v].tx[15] && vecs[v].n >= 16)
                chk($sformatf("tbl%0d_rx", v), rx, vecs[v].rx);
        end

        // Randomized frames against the model.
        for (int k = 0; k < 40; k++) begin
            int sel, n;
            logic [6:0] a;
            logic [15:0] tx;
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = 7'($urandom_range(0, 4));
            else if (sel < 8) a = 7'($urandom_range(0, 127));
            else              a = 7'h7F;
            tx = {1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))};
            n  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 16;
            do_frame(tx, n, rx, nstb);
            model_apply(tx, n, erx, estb);
            chk($sformatf("rnd%0d_strobes", k), nstb, estb);
            chk($sformatf("rnd%0d_wr_addr", k), wr_addr, m_wr_addr);
            chk($sformatf("rnd%0d_regs", k), regs_out, m_flat());
            if (!tx[15] && n >= 16) chk($sformatf("rnd%0d_rx", k), rx, erx);
        end

        // Make sure at least one register is nonzero before the reset test.
        do_frame(16'h80C3, 16, rx, nstb);
        model_apply(16'h80C3, 16, erx, estb);
        chk("pre_rst_regs", regs_out, m_flat());

        // Asynchronous reset in the middle of a read frame.
        strobes = 0;
        spi.nCS = 1'b0;
        tick(HALF);
        for (int i = 1; i <= 10; i++) begin
            spi.COPI = 1'b0;
            tick(HALF);
            spi.SCLK = 1'b1;
            tick(HALF);
        spi.SCLK = (i == 10) ? 1'b1 : 1'b0;
        end
        chk("pre_rst_oe", spi.cipo_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_regs", regs_out, 0);
        chk("async_rst_oe", spi.cipo_oe, 0);
        chk("async_rst_cipo", spi.CIPO, 0);
        chk("async_rst_wr_addr", wr_addr, 0);
        chk("async_rst_strobe", wr_strobe, 0);
        $display("async reset mid-frame regs=%010h oe=%0b", regs_out, spi.cipo_oe);
        spi.SCLK = 1'b0;
        spi.nCS  = 1'b1;
        tick(4);
        rst_n = 1'b1;
        model_reset();
        tick(4);

        // Back-to-back write then readback after reset.
        do_frame(16'h835A, 16, rx, nstb);
        model_apply(16'h835A, 16, erx, estb);
        chk("post_rst_strobes", nstb, 1);
        chk("post_rst_regs", regs_out, 40'h00_5A_00_00_00);
        do_frame(16'h0300, 16, rx, nstb);
        chk("post_rst_rx", rx, 8'h5A);

`ifdef SPI_STATUS_REG_EN
        // Status register: three aborts, a good write, then read/clear.
        for (int i = 0; i < 3; i++) begin
            do_frame(16'h8101, 5, rx, nstb);
            model_apply(16'h8101, 5, erx, estb);
        end
        do_frame(16'h8012, 16, rx, nstb);
        model_apply(16'h8012, 16, erx, estb);
        do_frame(16'h7F00, 16, rx, nstb);
        chk("status_rx", rx, 8'h07);
        do_frame(16'hFF00, 16, rx, nstb);
        model_apply(16'hFF00, 16, erx, estb);
        chk("status_clr_strobes", nstb, 0);
        do_frame(16'h7F00, 16, rx, nstb);
        chk("status_cleared_rx", rx, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
